// File: rtl/multi_channel_pressure_bcd.sv
// Multi-channel pressure front end: samples one raw channel per frame, normalises and clamps it,
// converts it to BCD with a serial double-dabble and presents it with a free-running digit strobe.
module multi_channel_pressure_bcd #(
    parameter int unsigned       N_CH          = 2,
    parameter int unsigned       IN_W          = 16,
    parameter int unsigned       DIGITS        = 4,
    parameter int unsigned       FRAME_CYCLES  = 10000000,
    parameter int unsigned       STROBE_CYCLES = 100000,
    parameter int unsigned       OFFSET        = 500,
    parameter int unsigned       SCALE_MUL     = 15,
    parameter int unsigned       SCALE_SHIFT   = 2,
    parameter logic [IN_W-1:0]   RAW_MAX       = IN_W'(16'hFFD0),
    parameter logic [DIGITS-1:0] DP_MASK       = DIGITS'(4'b1011),
    localparam int unsigned      CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned      SC_W          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_CH*IN_W-1:0]   RAW_IN,
    input  logic [CH_W-1:0]        CH_SEL,
    input  logic                   SCAN_EN,
    output logic [DIGITS*5-1:0]    DEC_VALUE,
    output logic [SC_W-1:0]        STROBE_COUNT,
    output logic [IN_W-1:0]        NORM_VALUE,
    output logic [CH_W-1:0]        CH_OUT,
    output logic                   VALID,
    output logic                   OVER,
    output logic                   BUSY
);

    localparam int unsigned PW   = IN_W + 8;
    localparam int unsigned BW   = DIGITS * 4;
    localparam int unsigned BC_W = $clog2(IN_W + 1);
    localparam int unsigned FR_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned PS_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [PW-1:0] LIMIT = PW'(pow10(DIGITS) - 1);

    // Attach the fixed decimal-point bit above each BCD nibble.
    function automatic logic [DIGITS*5-1:0] pack_dec(input logic [BW-1:0] bcd);
        logic [DIGITS*5-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*5 +: 5] = {DP_MASK[i], bcd[i*4 +: 4]};
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, SAMPLE, SCALE, CONV, LOAD} state_e;

    state_e              state_q;
    logic [FR_W-1:0]     frame_q;
    logic [PS_W-1:0]     psc_q;
    logic [SC_W-1:0]     strobe_q;
    logic [CH_W-1:0]     scan_q;
    logic [IN_W-1:0]     raw_q;
    logic [CH_W-1:0]     ch_q;
    logic [BW+IN_W-1:0]  sr_q;
    logic [BC_W-1:0]     bit_q;
    logic [IN_W-1:0]     norm_hold_q;
    logic                clamp_q;
    logic [DIGITS*5-1:0] dec_q;
    logic [IN_W-1:0]     norm_q;
    logic [CH_W-1:0]     ch_out_q;
    logic                valid_q;
    logic                over_q;
    logic                busy_q;

    logic                tick_c;
    logic [CH_W-1:0]     sel_d;
    logic [CH_W-1:0]     scan_d;
    logic [PW-1:0]       scaled_d;
    logic                over_rng_d;
    logic                clamp_d;
    logic [IN_W-1:0]     norm_d;
    logic [BW+IN_W-1:0]  sr_adj;
    logic [BW+IN_W-1:0]  sr_d;

    assign tick_c = (frame_q == FR_W'(FRAME_CYCLES - 1));

    // Frame timer and digit strobe run freely, independent of the conversion.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frame_q  <= '0;
            psc_q    <= '0;
            strobe_q <= '0;
        end else begin
            frame_q <= tick_c ? '0 : frame_q + FR_W'(1);
            if (psc_q == PS_W'(STROBE_CYCLES - 1)) begin
                psc_q    <= '0;
                strobe_q <= (strobe_q == SC_W'(DIGITS - 1)) ? '0 : strobe_q + SC_W'(1);
            end else begin
                psc_q <= psc_q + PS_W'(1);
            end
        end
    end

    // Channel selection; out-of-range fixed selections fall back to channel 0.
    always_comb begin
        scan_d = (scan_q == CH_W'(N_CH - 1)) ? '0 : scan_q + CH_W'(1);
        if (SCAN_EN)                    sel_d = scan_q;
        else if (32'(CH_SEL) >= N_CH)   sel_d = '0;
        else                            sel_d = CH_SEL;
    end

    always_comb begin
        scaled_d = ((PW'(raw_q) - PW'(OFFSET)) * PW'(SCALE_MUL)) >> SCALE_SHIFT;
        if (PW'(raw_q) <= PW'(OFFSET)) scaled_d = '0;
        over_rng_d = (raw_q > RAW_MAX);
        clamp_d    = (scaled_d > LIMIT);
        norm_d     = clamp_d ? IN_W'(LIMIT) : IN_W'(scaled_d);
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[IN_W + i*4 +: 4] >= 4'd5) sr_adj[IN_W + i*4 +: 4] = sr_q[IN_W + i*4 +: 4] + 4'd3;
        end
        sr_d = sr_adj << 1;
    end

    // Outputs are written on the transition into LOAD so VALID is high during LOAD.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            raw_q       <= '0;
            ch_q        <= '0;
            sr_q        <= '0;
            bit_q       <= '0;
            norm_hold_q <= '0;
            clamp_q     <= 1'b0;
            dec_q       <= pack_dec('0);
            norm_q      <= '0;
            ch_out_q    <= '0;
            valid_q     <= 1'b0;
            over_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_c) begin
                        state_q <= SAMPLE;
                        busy_q  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    raw_q <= RAW_IN[sel_d*IN_W +: IN_W];
                    ch_q  <= sel_d;
                    if (SCAN_EN) scan_q <= scan_d;
                    state_q <= SCALE;
                end
                SCALE: begin
                    if (over_rng_d) begin
                        dec_q    <= pack_dec('1);
                        norm_q   <= '0;
                        ch_out_q <= ch_q;
                        over_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= LOAD;
                    end else begin
                        sr_q        <= {BW'(0), norm_d};
                        bit_q       <= '0;
                        norm_hold_q <= norm_d;
                        clamp_q     <= clamp_d;
                        state_q     <= CONV;
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    bit_q <= bit_q + BC_W'(1);
                    if (bit_q == BC_W'(IN_W - 1)) begin
                        dec_q    <= pack_dec(sr_d[IN_W +: BW]);
                        norm_q   <= norm_hold_q;
                        ch_out_q <= ch_q;
                        over_q   <= clamp_q;
                        valid_q  <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DEC_VALUE    = dec_q;
    assign STROBE_COUNT = strobe_q;
    assign NORM_VALUE   = norm_q;
    assign CH_OUT       = ch_out_q;
    assign VALID        = valid_q;
    assign OVER         = over_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_multi_channel_pressure_bcd.sv
// Scoreboard bench: a frame-level reference model predicts each sampled conversion and its VALID cycle;
// a monitor pops and compares on every VALID and checks that outputs hold in between.
module tb_multi_channel_pressure_bcd;

    localparam int unsigned N_CH = 3;
    localparam int unsigned IN_W = 16;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned FC = 10;
    localparam int unsigned SC = 3;
    localparam logic [3:0]  DP = 4'b1011;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic [N_CH*IN_W-1:0] RAW_IN = '0;
    logic [1:0]           CH_SEL = '0;
    logic                 SCAN_EN = 1'b0;
    logic [DIGITS*5-1:0]  DEC_VALUE;
    logic [1:0]           STROBE_COUNT;
    logic [IN_W-1:0]      NORM_VALUE;
    logic [1:0]           CH_OUT;
    logic                 VALID;
    logic                 OVER;
    logic                 BUSY;

    multi_channel_pressure_bcd #(
        .N_CH(N_CH), .IN_W(IN_W), .DIGITS(DIGITS),
        .FRAME_CYCLES(FC), .STROBE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .RAW_IN(RAW_IN), .CH_SEL(CH_SEL), .SCAN_EN(SCAN_EN),
        .DEC_VALUE(DEC_VALUE), .STROBE_COUNT(STROBE_COUNT), .NORM_VALUE(NORM_VALUE),
        .CH_OUT(CH_OUT), .VALID(VALID), .OVER(OVER), .BUSY(BUSY)
    );

    typedef struct {
        logic [19:0] dec;
        logic [15:0] norm;
        logic [1:0]  ch;
        logic        over;
        int          vcyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Model state: k = edges since reset release, free_e = first edge a tick can be accepted.
    int   k, free_e, busy_s, scan_m;
    bit   pending, want_reset;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic exp_t ref_model(input int raw, input int ch);
        exp_t e;
        int   n, d;
        logic [3:0] nib;
        e.ch = 2'(ch);
        e.vcyc = 0;
        if (raw > 'hFFD0) begin
            e.over = 1'b1;
            e.norm = '0;
            n = -1;
        end else begin
            n = (raw <= 500) ? 0 : ((raw - 500) * 15) / 4;
            e.over = (n > 9999);
            if (n > 9999) n = 9999;
            e.norm = 16'(n);
        end
        d = 1;
        for (int i = 0; i < 4; i++) begin
            nib = (n < 0) ? 4'hF : 4'((n / d) % 10);
            e.dec[i*5 +: 5] = {DP[i], nib};
            d = d * 10;
        end
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = ref_model(0, 0);
        return e;
    endfunction

    task automatic do_reset();
        held = reset_exp();
        RESET = 1'b0;
        #1;
        check("rst_dec", DEC_VALUE, held.dec);
        check("rst_norm", NORM_VALUE, 0);
        check("rst_ch_out", CH_OUT, 0);
        check("rst_over", OVER, 0);
        check("rst_valid", VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_strobe", STROBE_COUNT, 0);
        sb_q.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        k = 0; free_e = 0; busy_s = -100; scan_m = 0; pending = 1'b0; want_reset = 1'b0;
    endtask

    // Per-cycle checks, then drive inputs for the coming edge and predict what that edge does.
    task automatic body(input logic [N_CH*IN_W-1:0] raw, input logic [1:0] sel, input logic scan);
        check("strobe", STROBE_COUNT, (k / SC) % DIGITS);
        check("busy", BUSY, (cyc >= busy_s && cyc < free_e - 1) ? 1 : 0);
        RAW_IN = raw;
        CH_SEL = sel;
        SCAN_EN = scan;
        if (pending) begin
            int   ch, rv;
            exp_t e;
            if (scan) begin
                ch = scan_m;
                scan_m = (scan_m + 1) % N_CH;
            end else begin
                ch = (sel >= N_CH) ? 0 : int'(sel);
            end
            rv = int'(raw[ch*IN_W +: IN_W]);
            e = ref_model(rv, ch);
            free_e = cyc + ((rv > 'hFFD0) ? 4 : 4 + IN_W);
            e.vcyc = free_e - 2;
            sb_q.push_back(e);
            pending = 1'b0;
        end else if ((k % FC) == FC - 1 && cyc + 1 >= free_e) begin
            pending = 1'b1;
            busy_s = cyc + 1;
            free_e = cyc + 1 + 100;
        end
        k++;
    endtask

    task automatic step(input logic [N_CH*IN_W-1:0] raw, input logic [1:0] sel, input logic scan);
        @(negedge CLK);
        if (want_reset && !pending && cyc == busy_s + 8 && free_e == busy_s + 4 + IN_W)
            do_reset();
        body(raw, sel, scan);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge CLK);
            #2;
            if (VALID) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL valid_unexpected: got VALID=1 expected no pending result at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("dec_value", DEC_VALUE, e.dec);
                    check("norm_value", NORM_VALUE, e.norm);
                    check("ch_out", CH_OUT, e.ch);
                    check("over", OVER, e.over);
                    check("latency", cyc, e.vcyc);
                    held = e;
                end
            end else if (RESET) begin
                check("hold_dec", DEC_VALUE, held.dec);
                check("hold_norm", NORM_VALUE, held.norm);
                check("hold_ch", CH_OUT, held.ch);
                check("hold_over", OVER, held.over);
            end
        end
    end

    int unsigned dvals [11] = '{1000, 500, 501, 3500, 'hFFE0, 'hFFD0, 'hFFD1, 0, 3166, 3167, 2000};

    initial begin
        logic [N_CH*IN_W-1:0] r;
        logic                 sc;
        held = reset_exp();
        @(negedge CLK);
        do_reset();
        body('0, 2'd0, 1'b0);

        // Directed values on every channel so the sample instant does not matter.
        foreach (dvals[i]) begin
            r = {3{16'(dvals[i])}};
            repeat (30) step(r, 2'($urandom_range(0, 3)), 1'b0);
        end

        r = {16'd800, 16'd700, 16'd600};
        repeat (120) step(r, 2'd0, 1'b1);

        sc = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int ch = 0; ch < N_CH; ch++)
                r[ch*IN_W +: IN_W] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3300));
            if ($urandom_range(0, 49) == 0) sc = ~sc;
            if (c == 1000) want_reset = 1'b1;
            step(r, 2'($urandom_range(0, 3)), sc);
        end

        repeat (30) step(r, 2'd0, 1'b0);
        @(negedge CLK);
        #3;
        check("no_overdue_result", (sb_q.size() > 0 && sb_q[0].vcyc <= cyc) ? 1 : 0, 0);
        check("reset_mid_conv_taken", want_reset, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
